// File: rtl/screen_console_if.sv
// Handshake and display-read signals between the character source, the
// display driver and the screen console.
interface screen_console_if #(
  parameter int unsigned SM_LEN       = 11,
  parameter int unsigned ALPHABET_LEN = 6
);
  logic [ALPHABET_LEN-1:0] in_char;
  logic                    in_valid;
  logic                    in_ready;
  logic [SM_LEN-1:0]       sm_addr;
  logic [ALPHABET_LEN-1:0] char_code;
  logic [4:0]              cursor_row;
  logic [5:0]              cursor_col;
  logic                    busy;

  modport master (
    output in_char, in_valid, sm_addr,
    input  in_ready, char_code, cursor_row, cursor_col, busy
  );

  modport slave (
    input  in_char, in_valid, sm_addr,
    output in_ready, char_code, cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/screen_console.sv
// Text-mode screen memory with a cursor-driven write controller. Character
// codes arrive over valid/ready; control codes handle backspace, newline and
// clear. The display side reads through a registered, range-gated port.
module screen_console #(
  parameter int unsigned SM_LEN       = 11,
  parameter int unsigned ALPHABET_LEN = 6,
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 30
) (
  input logic             clock,
  input logic             reset,
  screen_console_if.slave bus
);
  localparam int unsigned ColW = 6;
  localparam int unsigned RowW = SM_LEN - ColW;

  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColsL   = ColW'(COLS);
  localparam logic [RowW-1:0] RowsL   = RowW'(ROWS);

  localparam logic [ALPHABET_LEN-1:0] LastGlyph = ALPHABET_LEN'(36);
  localparam logic [ALPHABET_LEN-1:0] CodeBs    = ALPHABET_LEN'(61);
  localparam logic [ALPHABET_LEN-1:0] CodeNl    = ALPHABET_LEN'(62);
  localparam logic [ALPHABET_LEN-1:0] CodeClr   = ALPHABET_LEN'(63);

  typedef enum logic [1:0] {StClearAll, StIdle, StClearRow} state_e;

  state_e                  state_q;
  logic [RowW-1:0]         row_q, clr_row_q;
  logic [ColW-1:0]         col_q, clr_col_q;
  logic                    in_ready_q, busy_q;
  logic [ALPHABET_LEN-1:0] char_code_q;

  logic [ALPHABET_LEN-1:0] mem [2**SM_LEN];

  logic                    accept, is_print, is_bs, is_nl, is_clr, row_adv;
  logic [RowW-1:0]         next_row;
  logic                    we;
  logic [SM_LEN-1:0]       waddr;
  logic [ALPHABET_LEN-1:0] wdata;
  logic [RowW-1:0]         rd_row;
  logic [ColW-1:0]         rd_col;

  // in_ready_q is only high in StIdle, so every decoded code implies StIdle.
  assign accept   = bus.in_valid && in_ready_q;
  assign is_print = accept && (bus.in_char <= LastGlyph);
  assign is_bs    = accept && (bus.in_char == CodeBs);
  assign is_nl    = accept && (bus.in_char == CodeNl);
  assign is_clr   = accept && (bus.in_char == CodeClr);
  assign row_adv  = is_nl || (is_print && (col_q == LastCol));
  assign next_row = (row_q == LastRow) ? '0 : row_q + RowW'(1);

  assign rd_row = bus.sm_addr[SM_LEN-1:ColW];
  assign rd_col = bus.sm_addr[ColW-1:0];

  // Write-port selection: clear sweeps, glyph stores and backspace erase.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    unique case (state_q)
      StClearAll: begin
        we    = 1'b1;
        waddr = {clr_row_q, clr_col_q};
      end
      StClearRow: begin
        we    = 1'b1;
        waddr = {row_q, clr_col_q};
      end
      StIdle: begin
        if (is_print) begin
          we    = 1'b1;
          waddr = {row_q, col_q};
          wdata = bus.in_char;
        end else if (is_bs && (col_q != '0)) begin
          we    = 1'b1;
          waddr = {row_q, col_q - ColW'(1)};
        end
      end
      default: ;
    endcase
    // An edge with reset high must not commit anything.
    if (reset) we = 1'b0;
  end

  // Screen memory write port.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Display read port; off-screen addresses read as blank.
  always_ff @(posedge clock) begin
    if (reset) begin
      char_code_q <= '0;
    end else if ((rd_row < RowsL) && (rd_col < ColsL)) begin
      char_code_q <= mem[bus.sm_addr];
    end else begin
      char_code_q <= '0;
    end
  end

  // Controller FSM with cursor, clear counter and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StClearAll;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StClearAll: begin
          if (clr_col_q == LastCol) begin
            clr_col_q <= '0;
            if (clr_row_q == LastRow) begin
              clr_row_q  <= '0;
              state_q    <= StIdle;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              clr_row_q <= clr_row_q + RowW'(1);
            end
          end else begin
            clr_col_q <= clr_col_q + ColW'(1);
          end
        end
        StIdle: begin
          if (is_clr) begin
            state_q    <= StClearAll;
            row_q      <= '0;
            col_q      <= '0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (row_adv) begin
            state_q    <= StClearRow;
            row_q      <= next_row;
            col_q      <= '0;
            clr_col_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (is_print) begin
            col_q <= col_q + ColW'(1);
          end else if (is_bs && (col_q != '0)) begin
            col_q <= col_q - ColW'(1);
          end
        end
        StClearRow: begin
          if (clr_col_q == LastCol) begin
            clr_col_q  <= '0;
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_col_q <= clr_col_q + ColW'(1);
          end
        end
        default: begin
          state_q <= StClearAll;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.char_code  = char_code_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
endmodule
